// File: rtl/reg_wb_scheduler.sv
// rtl/reg_wb_scheduler.sv - Writeback scheduler onto E/M register write slots with host injection.
// Optional conflict counter: define WB_CONFLICT_CNT_EN.
module reg_wb_scheduler #(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              e_valid,
    input  logic [2:0]        e_dst,
    input  logic [DATA_W-1:0] e_val,
    input  logic              m_valid,
    input  logic [2:0]        m_dst,
    input  logic [DATA_W-1:0] m_val,
    output logic              in_ready,
    input  logic              h_valid,
    input  logic [2:0]        h_dst,
    input  logic [DATA_W-1:0] h_val,
    output logic              h_ready,
    output logic              reqE,
    output logic [2:0]        dstE,
    output logic [DATA_W-1:0] valE,
    output logic              reqM,
    output logic [2:0]        dstM,
    output logic [DATA_W-1:0] valM
`ifdef WB_CONFLICT_CNT_EN
    ,
    output logic [CNT_W-1:0]  conflict_cnt
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_SPLIT,
        ST_FORCE_HOST
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [2:0]        hold_dst_q, hold_dst_d;
    logic [DATA_W-1:0] hold_val_q, hold_val_d;
    logic              req_e_q, req_e_d;
    logic [2:0]        dst_e_q, dst_e_d;
    logic [DATA_W-1:0] val_e_q, val_e_d;
    logic              req_m_q, req_m_d;
    logic [2:0]        dst_m_q, dst_m_d;
    logic [DATA_W-1:0] val_m_q, val_m_d;
    logic              conflict;

    assign in_ready = (state_q == ST_NORMAL);
    assign conflict = (state_q == ST_NORMAL) & e_valid & m_valid & (e_dst == m_dst);

    assign reqE = req_e_q;
    assign dstE = dst_e_q;
    assign valE = val_e_q;
    assign reqM = req_m_q;
    assign dstM = dst_m_q;
    assign valM = val_m_q;

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        hold_dst_d = hold_dst_q;
        hold_val_d = hold_val_q;
        req_e_d    = 1'b0;
        dst_e_d    = dst_e_q;
        val_e_d    = val_e_q;
        req_m_d    = 1'b0;
        dst_m_d    = dst_m_q;
        val_m_d    = val_m_q;
        h_ready    = 1'b0;

        case (state_q)
            ST_NORMAL: begin
                if (conflict) begin
                    // E goes now, M is parked so it lands one cycle later and wins.
                    req_e_d    = 1'b1;
                    dst_e_d    = e_dst;
                    val_e_d    = e_val;
                    hold_dst_d = m_dst;
                    hold_val_d = m_val;
                    state_d    = ST_SPLIT;
                end else begin
                    if (e_valid) begin
                        req_e_d = 1'b1;
                        dst_e_d = e_dst;
                        val_e_d = e_val;
                    end
                    if (m_valid) begin
                        req_m_d = 1'b1;
                        dst_m_d = m_dst;
                        val_m_d = m_val;
                    end
                    if (h_valid && !e_valid && !(m_valid && (m_dst == h_dst))) begin
                        h_ready = 1'b1;
                        req_e_d = 1'b1;
                        dst_e_d = h_dst;
                        val_e_d = h_val;
                    end
                end
            end
            ST_SPLIT: begin
                req_m_d = 1'b1;
                dst_m_d = hold_dst_q;
                val_m_d = hold_val_q;
                if (h_valid && (h_dst != hold_dst_q)) begin
                    h_ready = 1'b1;
                    req_e_d = 1'b1;
                    dst_e_d = h_dst;
                    val_e_d = h_val;
                end
                state_d = ST_NORMAL;
            end
            ST_FORCE_HOST: begin
                if (h_valid) begin
                    h_ready = 1'b1;
                    req_e_d = 1'b1;
                    dst_e_d = h_dst;
                    val_e_d = h_val;
                end
                state_d = ST_NORMAL;
            end
            default: state_d = ST_NORMAL;
        endcase

        if (!h_valid || h_ready) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end

        // A conflict wins over forcing; the saturated count forces right after the split.
        if ((state_q == ST_NORMAL) && !conflict && h_valid && !h_ready && (starve_d == STARVE_MAX)) begin
            state_d = ST_FORCE_HOST;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_NORMAL;
            starve_q   <= '0;
            hold_dst_q <= '0;
            hold_val_q <= '0;
            req_e_q    <= 1'b0;
            dst_e_q    <= '0;
            val_e_q    <= '0;
            req_m_q    <= 1'b0;
            dst_m_q    <= '0;
            val_m_q    <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            hold_dst_q <= hold_dst_d;
            hold_val_q <= hold_val_d;
            req_e_q    <= req_e_d;
            dst_e_q    <= dst_e_d;
            val_e_q    <= val_e_d;
            req_m_q    <= req_m_d;
            dst_m_q    <= dst_m_d;
            val_m_q    <= val_m_d;
        end
    end

`ifdef WB_CONFLICT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign conflict_cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (conflict && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // CNT_W only sizes the counter; this keeps it referenced when the counter is absent.
    if (CNT_W < 1) begin : g_cnt_w_invalid
    end
`endif

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// tb/tb_reg_wb_scheduler.sv - Directed scoreboard bench for reg_wb_scheduler.
module tb_reg_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        e_valid, m_valid, h_valid;
    logic [2:0]  e_dst, m_dst, h_dst;
    logic [31:0] e_val, m_val, h_val;
    logic        in_ready, h_ready;
    logic        reqE, reqM;
    logic [2:0]  dstE, dstM;
    logic [31:0] valE, valM;
`ifdef WB_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        re;
        logic [2:0]  de;
        logic [31:0] ve;
        logic        rm;
        logic [2:0]  dm;
        logic [31:0] vm;
    } exp_t;

    exp_t sb[$];

    reg_wb_scheduler #(
        .DATA_W      (32),
        .STARVE_LIMIT(4),
        .CNT_W       (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .e_valid (e_valid),
        .e_dst   (e_dst),
        .e_val   (e_val),
        .m_valid (m_valid),
        .m_dst   (m_dst),
        .m_val   (m_val),
        .in_ready(in_ready),
        .h_valid (h_valid),
        .h_dst   (h_dst),
        .h_val   (h_val),
        .h_ready (h_ready),
        .reqE    (reqE),
        .dstE    (dstE),
        .valE    (valE),
        .reqM    (reqM),
        .dstM    (dstM),
        .valM    (valM)
`ifdef WB_CONFLICT_CNT_EN
        ,
        .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed hang, required finish)");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [2:0] ed, input logic [31:0] evl,
                         input logic mv, input logic [2:0] md, input logic [31:0] mvl,
                         input logic hv, input logic [2:0] hd, input logic [31:0] hvl);
        e_valid = ev; e_dst = ed; e_val = evl;
        m_valid = mv; m_dst = md; m_val = mvl;
        h_valid = hv; h_dst = hd; h_val = hvl;
    endtask

    // Checks handshakes for the driven inputs, queues the slot writes expected next cycle,
    // then clocks and compares against the oldest queued expectation.
    task automatic cyc(input string tag, input logic ir, input logic hr,
                       input logic re, input logic [2:0] de, input logic [31:0] ve,
                       input logic rm, input logic [2:0] dm, input logic [31:0] vm);
        exp_t x;
        #1;
        chk({tag, ".in_ready"}, in_ready, ir);
        chk({tag, ".h_ready"}, h_ready, hr);
        x = '{re, de, ve, rm, dm, vm};
        sb.push_back(x);
        @(posedge clk);
        #1;
        n_tests++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk({tag, ".reqE"}, reqE, x.re);
            if (x.re) begin
                chk({tag, ".dstE"}, dstE, x.de);
                chk({tag, ".valE"}, valE, x.ve);
            end
            chk({tag, ".reqM"}, reqM, x.rm);
            if (x.rm) begin
                chk({tag, ".dstM"}, dstM, x.dm);
                chk({tag, ".valM"}, valM, x.vm);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #22;
        chk("rst.reqE", reqE, 0);
        chk("rst.reqM", reqM, 0);
        chk("rst.dstE", dstE, 0);
        chk("rst.dstM", dstM, 0);
        chk("rst.valE", valE, 0);
        chk("rst.valM", valM, 0);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.h_ready", h_ready, 0);
`ifdef WB_CONFLICT_CNT_EN
        chk("rst.conflict_cnt", conflict_cnt, 0);
`endif
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Independent E and M writes
        drive(1, 3, 32'h11, 1, 5, 32'h22, 0, 0, 0);
        cyc("indep", 1, 0, 1, 3, 32'h11, 1, 5, 32'h22);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("idle", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("idle.dstE_hold", dstE, 3);
        chk("idle.valM_hold", valM, 32'h22);

        // Same-register conflict splits into E then M
        drive(1, 4, 32'hAAAA, 1, 4, 32'hBBBB, 0, 0, 0);
        cyc("conf", 1, 0, 1, 4, 32'hAAAA, 0, 0, 0);
        cyc("split", 0, 0, 0, 0, 0, 1, 4, 32'hBBBB);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("postsplit", 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef WB_CONFLICT_CNT_EN
        chk("conf.conflict_cnt", conflict_cnt, 1);
`endif

        // Host grant alongside an M write
        drive(0, 0, 0, 1, 6, 32'h9, 1, 2, 32'h7);
        cyc("hgrant", 1, 1, 1, 2, 32'h7, 1, 6, 32'h9);

        // Host blocked by M to the same register, granted next free cycle
        drive(0, 0, 0, 1, 6, 32'h44, 1, 6, 32'h33);
        cyc("hblk", 1, 0, 0, 0, 0, 1, 6, 32'h44);
        drive(0, 0, 0, 0, 0, 0, 1, 6, 32'h33);
        cyc("hnext", 1, 1, 1, 6, 32'h33, 0, 0, 0);

        // Host takes the E slot during a split
        drive(1, 7, 32'h1, 1, 7, 32'h2, 1, 0, 32'h5A);
        cyc("hsplit.conf", 1, 0, 1, 7, 32'h1, 0, 0, 0);
        cyc("hsplit.split", 0, 1, 1, 0, 32'h5A, 1, 7, 32'h2);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("hsplit.idle", 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef WB_CONFLICT_CNT_EN
        chk("hsplit.conflict_cnt", conflict_cnt, 2);
`endif

        // Starvation forces a host grant after STARVE_LIMIT waits
        for (int i = 0; i < 4; i++) begin
            drive(1, 3'(i + 2), 32'h100 + i, 0, 0, 0, 1, 1, 32'h55);
            cyc($sformatf("starve%0d", i), 1, 0, 1, 3'(i + 2), 32'h100 + i, 0, 0, 0);
        end
        cyc("force", 0, 1, 1, 1, 32'h55, 0, 0, 0);
        drive(1, 5, 32'h103, 0, 0, 0, 0, 0, 0);
        cyc("postforce", 1, 0, 1, 5, 32'h103, 0, 0, 0);

        // Forced slot with the host request withdrawn issues nothing
        for (int i = 0; i < 4; i++) begin
            drive(1, 3, 32'h200 + i, 0, 0, 0, 1, 4, 32'h66);
            cyc($sformatf("starveb%0d", i), 1, 0, 1, 3, 32'h200 + i, 0, 0, 0);
        end
        drive(1, 3, 32'h203, 0, 0, 0, 0, 0, 0);
        cyc("force_drop", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("postdrop", 1, 0, 1, 3, 32'h203, 0, 0, 0);

        // Reset in the middle of a split drops the held M write
        drive(1, 2, 32'hC, 1, 2, 32'hD, 0, 0, 0);
        cyc("rsplit.conf", 1, 0, 1, 2, 32'hC, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("rsplit.reqE", reqE, 0);
        chk("rsplit.valE", valE, 0);
        chk("rsplit.in_ready", in_ready, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        cyc("rsplit.after", 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef WB_CONFLICT_CNT_EN
        chk("rsplit.conflict_cnt", conflict_cnt, 0);
`endif

        n_tests++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_wb_scheduler.md
Name: reg_wb_scheduler

Overview:
Sequences register-file writeback requests onto the two write slots (E slot, M slot) that feed the register write decoder.
- Pipeline side: presents an E write and an M write per cycle.
- Host/debug side: injects single register writes.
- Same-register E/M collisions are split into two ordered cycles so the M value lands last.
- Host writes take free E slots, with a starvation guarantee.

Parameters:
DATA_W, 32, register data width
STARVE_LIMIT, 8, consecutive cycles a pending host write may wait before a forced grant (min 1)
CNT_W, 16, conflict counter width (optional feature only)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
e_valid  input  1  pipeline E write request
e_dst  input  3  E destination register
e_val  input  DATA_W  E write data
m_valid  input  1  pipeline M write request
m_dst  input  3  M destination register
m_val  input  DATA_W  M write data
in_ready  output  1  pipeline requests accepted this cycle; pipeline holds inputs when low
h_valid  input  1  host write request
h_dst  input  3  host destination register
h_val  input  DATA_W  host write data
h_ready  output  1  host request accepted this cycle
reqE  output  1  E slot write enable (registered)
dstE  output  3  E slot register index (registered)
valE  output  DATA_W  E slot data (registered)
reqM  output  1  M slot write enable (registered)
dstM  output  3  M slot register index (registered)
valM  output  DATA_W  M slot data (registered)
conflict_cnt  output  CNT_W  same-register conflict count (optional feature only)

Behaviour:
- Clock is clk; reset is asynchronous, active-low (rst_n).
- Reset state:
  - reqE=reqM=0; dstE=dstM=0; valE=valM=0.
  - state=NORMAL; starve counter=0; hold register cleared; conflict_cnt=0.
  - Reset asserted mid-SPLIT drops the held M write.
- Latency: all slot outputs are registered. A request accepted in cycle N appears in cycle N+1.
- Pulse rule: reqE/reqM are 1-cycle pulses. Both default to 0 every cycle unless an issue is registered.
- in_ready = (state==NORMAL) and depends on state only. Pipeline requests are sampled only when in_ready=1.
- h_ready is combinational (Mealy):
  - 1 only in the cycle the host write is issued;
  - never 1 when h_valid=0.
- States: NORMAL, SPLIT, FORCE_HOST.
- NORMAL, no conflict (not (e_valid & m_valid & e_dst==m_dst)):
  - register E request onto the E slot and M request onto the M slot, as present.
  - Host grant if h_valid & !e_valid & !(m_valid & m_dst==h_dst): host goes onto the E slot and the starve counter clears.
- NORMAL, conflict (e_valid & m_valid & e_dst==m_dst):
  - issue E only (reqM=0);
  - latch m_dst/m_val into hold; next state SPLIT;
  - no host grant this cycle.
- SPLIT:
  - in_ready=0; issue hold on the M slot; next state NORMAL.
  - Host may take the E slot if h_valid & h_dst!=hold dst.
- Starvation:
  - counter increments each cycle h_valid & !h_ready; saturates at STARVE_LIMIT.
  - Counter drops to 0 whenever h_valid=0.
  - In NORMAL with counter==STARVE_LIMIT and no host grant possible, next state is FORCE_HOST.
- FORCE_HOST:
  - in_ready=0; if h_valid, issue host on the E slot with h_ready=1.
  - Counter clears; next state NORMAL.
  - If h_valid has dropped, no issue; return to NORMAL.
- Ordering guarantees:
  - Never drive reqE and reqM together with dstE==dstM.
  - For an E/M conflict, E is always written one cycle before M.
- Unused slot data/dst hold their previous values (don't-care when req=0).

Optional Feature:
Macro WB_CONFLICT_CNT_EN.
- Defined: conflict_cnt port exists. It increments by 1 on each NORMAL-state conflict acceptance, saturating at all-ones, and clears on reset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Independent writes: e_valid dst=3 val=0x11, m_valid dst=5 val=0x22 -> next cycle reqE=1 dstE=3 valE=0x11, reqM=1 dstM=5 valM=0x22; in_ready stays 1.
- Conflict: e_valid dst=4 val=0xAAAA, m_valid dst=4 val=0xBBBB -> cycle+1: reqE=1 dstE=4 valE=0xAAAA, reqM=0, in_ready=0; cycle+2: reqM=1 dstM=4 valM=0xBBBB, reqE=0; in_ready=1 from cycle+2; conflict_cnt=1 with WB_CONFLICT_CNT_EN.
- Host grant: h_valid dst=2 val=0x7, e_valid=0, m_valid dst=6 val=0x9 -> h_ready=1 same cycle; next cycle reqE dstE=2 valE=0x7 and reqM dstM=6 valM=0x9.
- Host blocked by M collision: h_valid dst=6, m_valid dst=6, e_valid=0 -> h_ready=0, only reqM issued; host granted the next free cycle.
- Starvation with STARVE_LIMIT=4: e_valid=1 every cycle, h_valid dst=1 val=0x55 held -> h_ready=0 for 4 cycles; then one FORCE_HOST cycle with in_ready=0, h_ready=1; next cycle reqE dstE=1 valE=0x55.
- Reset mid-SPLIT: assert rst_n=0 the cycle after a conflict -> outputs 0 immediately (async), no reqM after release, in_ready=1.
